// File: rtl/uart_pkg.sv
// Line-format constants and receiver state encoding shared by the UART blocks.
package uart_pkg;

  localparam int default_cycles_per_bit = 434;
  localparam int data_bits              = 8;

  typedef enum logic [2:0] {
    idle      = 3'd0,
    start     = 3'd1,
    data      = 3'd2,
    stop      = 3'd3,
    wait_high = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream leaving the receiver.
// Handshake: a byte moves on every rising clk edge where tvalid && tready are both high;
// the master holds tvalid and tdata stable until that edge, and the slave may drive
// tready freely (it may depend on tvalid).
interface uart_rx_if;
  import uart_pkg::*;

  logic                 tvalid;
  logic                 tready;
  logic [data_bits-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: centre-samples each bit and presents bytes on a stream master.
// framing_error pulses when the stop bit is low; overflow pulses when a byte completes
// while the previous one is still waiting for the sink (the new byte is dropped).
module uart_rx
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = default_cycles_per_bit
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uart_rx_if.master      m_axis,
  output logic           framing_error,
  output logic           overflow,
  output uart_rx_state_t state_o
);

  localparam int CW = $clog2(cycles_per_bit);
  localparam logic [CW-1:0] half_m1 = CW'(cycles_per_bit / 2 - 1);
  localparam logic [CW-1:0] full_m1 = CW'(cycles_per_bit - 1);

  logic rx_s;

  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [2:0]           idx_q, idx_d;
  logic [data_bits-1:0] shift_q, shift_d;

  logic [data_bits-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovf_q, ovf_d;

  // FSM strobes
  logic half_hit, full_hit;
  logic cyc_clr, cyc_inc, idx_clr, idx_inc, shift_en, deliver, frame_err;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign half_hit = (cyc_q == half_m1);
  assign full_hit = (cyc_q == full_m1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= idle;
    else        state_q <= state_d;
  end

  // Next-state decision from the synchronised line and the bit timers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      idle:      if (!rx_s) state_d = start;
      start:     if (half_hit) state_d = rx_s ? idle : data;
      data:      if (full_hit && idx_q == 3'd7) state_d = stop;
      stop:      if (full_hit) state_d = rx_s ? idle : wait_high;
      wait_high: if (rx_s) state_d = idle;
      default:   state_d = idle;
    endcase
  end

  // Per-state strobes driving the counters, shift register and output register.
  always_comb begin
    cyc_clr   = 1'b0;
    cyc_inc   = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      idle, wait_high: cyc_clr = 1'b1;
      start: begin
        if (half_hit) begin
          cyc_clr = 1'b1;
          idx_clr = 1'b1;
        end else begin
          cyc_inc = 1'b1;
        end
      end
      data: begin
        if (full_hit) begin
          cyc_clr  = 1'b1;
          shift_en = 1'b1;
          idx_inc  = 1'b1;
        end else begin
          cyc_inc = 1'b1;
        end
      end
      stop: begin
        if (full_hit) begin
          cyc_clr   = 1'b1;
          deliver   = rx_s;
          frame_err = !rx_s;
        end else begin
          cyc_inc = 1'b1;
        end
      end
      default: cyc_clr = 1'b1;
    endcase
  end

  // Next values for the bit timer, bit index and LSB-first shift register.
  always_comb begin
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (cyc_clr)      cyc_d = '0;
    else if (cyc_inc) cyc_d = cyc_q + 1'b1;
    if (idx_clr)      idx_d = '0;
    else if (idx_inc) idx_d = idx_q + 1'b1;
    if (shift_en)     shift_d = {rx_s, shift_q[data_bits-1:1]};
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Output holding register: a completed byte is dropped only if the old one
  // is still pending and not being taken in this same cycle.
  always_comb begin
    ovf_d    = deliver && tvalid_q && !m_axis.tready;
    ferr_d   = frame_err;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    if (deliver && !ovf_d) begin
      tvalid_d = 1'b1;
      tdata_d  = shift_q;
    end else if (tvalid_q && m_axis.tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Output and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign framing_error = ferr_q;
  assign overflow      = ovf_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: serial frames are driven on rx, expected bytes
// are queued as each frame is sent and compared when the stream handshake completes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int cpb = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rx;
  logic           framing_error;
  logic           overflow;
  uart_rx_state_t state_o;

  uart_rx_if bus ();

  uart_rx #(.cycles_per_bit(cpb)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .m_axis        (bus),
    .framing_error (framing_error),
    .overflow      (overflow),
    .state_o       (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         n_xfer = 0;
  int         n_valid_cyc = 0;
  int         n_ferr = 0;
  int         n_ovf = 0;
  int         n_both = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tvalid) n_valid_cyc++;
      if (framing_error) n_ferr++;
      if (overflow) n_ovf++;
      if (framing_error && overflow) n_both++;
      if (bus.tvalid && bus.tready) begin
        n_xfer++;
        chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("tdata", 32'(bus.tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (cpb) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (cpb) tick();
    end
    rx = stop_bit;
    repeat (cpb) tick();
  endtask

  task automatic gap();
    repeat (2 * cpb) tick();
  endtask

  // ---------------- stimulus ----------------
  int x0;
  int v0;

  initial begin
    rst_n      = 1'b0;
    rx         = 1'b1;
    bus.tready = 1'b0;
    #1;
    chk("rst_tvalid", 32'(bus.tvalid), 32'd0);
    chk("rst_tdata", 32'(bus.tdata), 32'd0);
    chk("rst_ferr", 32'(framing_error), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_state", 32'(state_o), 32'(idle));
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // 1: two clean bytes, sink always ready
    bus.tready = 1'b1;
    x0 = n_xfer;
    v0 = n_valid_cyc;
    exp_q.push_back(8'h55); send_frame(8'h55, 1'b1); gap();
    exp_q.push_back(8'hA3); send_frame(8'hA3, 1'b1); gap();
    chk("t1_xfers", 32'(n_xfer - x0), 32'd2);
    chk("t1_valid_cycles", 32'(n_valid_cyc - v0), 32'd2);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: short low glitch is rejected silently
    x0 = n_xfer;
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (3 * cpb) tick();
    chk("t2_xfers", 32'(n_xfer - x0), 32'd0);
    chk("t2_ferr", 32'(n_ferr), 32'd0);
    chk("t2_state", 32'(state_o), 32'(idle));

    // 3: bad stop bit, line held low, then recovery
    x0 = n_xfer;
    send_frame(8'h3C, 1'b0);
    repeat (40) tick();
    chk("t3_ferr", 32'(n_ferr), 32'd1);
    chk("t3_state_wait", 32'(state_o), 32'(wait_high));
    chk("t3_tvalid", 32'(bus.tvalid), 32'd0);
    rx = 1'b1;
    repeat (4) tick();
    chk("t3_state_idle", 32'(state_o), 32'(idle));
    exp_q.push_back(8'h81); send_frame(8'h81, 1'b1); gap();
    chk("t3_xfers", 32'(n_xfer - x0), 32'd1);
    chk("t3_ferr_after", 32'(n_ferr), 32'd1);

    // 4: stalled sink, second byte overflows
    bus.tready = 1'b0;
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1); gap();
    send_frame(8'h22, 1'b1); gap();
    chk("t4_ovf", 32'(n_ovf), 32'd1);
    chk("t4_tvalid_held", 32'(bus.tvalid), 32'd1);
    chk("t4_tdata_held", 32'(bus.tdata), 32'h11);
    bus.tready = 1'b1;
    tick();
    chk("t4_tvalid_fall", 32'(bus.tvalid), 32'd0);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: sink accepts exactly in the cycle the second byte is delivered
    bus.tready = 1'b0;
    exp_q.push_back(8'h01); send_frame(8'h01, 1'b1); gap();
    exp_q.push_back(8'h02);
    fork
      send_frame(8'h02, 1'b1);
      begin
        int k;
        k = 0;
        while (state_o != stop && k < 20 * cpb) begin
          tick();
          k++;
        end
        chk("t5_reach_stop", 32'(state_o == stop), 32'd1);
        repeat (cpb - 1) tick();
        bus.tready = 1'b1;
        tick();
        bus.tready = 1'b0;
      end
    join
    gap();
    chk("t5_no_ovf", 32'(n_ovf), 32'd1);
    chk("t5_tvalid", 32'(bus.tvalid), 32'd1);
    chk("t5_tdata", 32'(bus.tdata), 32'h02);
    bus.tready = 1'b1;
    tick();
    chk("t5_tvalid_fall", 32'(bus.tvalid), 32'd0);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset in the middle of a frame, with a byte pending
    bus.tready = 1'b0;
    send_frame(8'h77, 1'b1); gap();
    chk("t6_pending_tvalid", 32'(bus.tvalid), 32'd1);
    chk("t6_pending_tdata", 32'(bus.tdata), 32'h77);
    rx = 1'b0;                               // start bit + low data bits of 0xF0
    repeat (4 * cpb + cpb / 2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(bus.tvalid), 32'd0);
    chk("t6_rst_tdata", 32'(bus.tdata), 32'd0);
    chk("t6_rst_ferr", 32'(framing_error), 32'd0);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    chk("t6_rst_state", 32'(state_o), 32'(idle));
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    bus.tready = 1'b1;
    x0 = n_xfer;
    exp_q.push_back(8'h0F); send_frame(8'h0F, 1'b1); gap();
    chk("t6_xfers", 32'(n_xfer - x0), 32'd1);

    // ---------------- final report ----------------
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_ferr_total", 32'(n_ferr), 32'd1);
    chk("final_ovf_total", 32'(n_ovf), 32'd1);
    chk("final_flags_exclusive", 32'(n_both), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
